// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared definitions for the arbitrated registered mux.
//   DEF_WIDTH - default data width per channel
//   state_t   - output register occupancy (EMPTY / FULL)
//   idx_w()   - width of a channel index for n channels (at least 1)
package mux_arb_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_arb_grant.sv
// mux_arb_grant: picks one requesting channel per cycle.
//   req - per-channel requests
//   ptr - highest-priority channel (round-robin build only)
//   gnt - one-hot grant, zero when no request
//   idx - binary index of the granted channel (0 when no request)
// Build option: MUX_ARB_RR_EN selects round-robin from ptr; otherwise
// fixed priority with channel 0 highest.
module mux_arb_grant
  import mux_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = idx_w(N)
) (
  input  logic [N-1:0]    req,
`ifdef MUX_ARB_RR_EN
  input  logic [SELW-1:0] ptr,
`endif
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx
);

`ifdef MUX_ARB_RR_EN
  // Walk offsets from the farthest to the nearest so the channel closest
  // to ptr (in wrap order) is the one that survives.
  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    c   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = SELW'(c);
      end
    end
  end
`else
  // Highest index first, lowest index overwrites: channel 0 wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = SELW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/mux_arb.sv
// mux_arb: N-channel arbitrated mux into a one-entry output register.
//   clk, reset          - clock, async active-high reset
//   in_valid/in_ready   - per-channel handshake (in_ready one-hot or zero)
//   in_data             - channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready - output handshake
//   out_data, out_sel   - registered winning word and its channel index
// Build option: MUX_ARB_RR_EN enables round-robin arbitration with a
// pointer register; otherwise fixed priority (lowest index wins).
module mux_arb
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = 4,
  localparam int SELW = idx_w(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  logic [N-1:0][WIDTH-1:0] words;
  logic [N-1:0]            gnt;
  logic [SELW-1:0]         gidx;
  logic                    load, take;
  state_t                  state_q, state_d;

  assign words = in_data;

`ifdef MUX_ARB_RR_EN
  logic [SELW-1:0] ptr_q;
`endif

  mux_arb_grant #(.N(N), .SELW(SELW)) u_grant (
    .req (in_valid),
`ifdef MUX_ARB_RR_EN
    .ptr (ptr_q),
`endif
    .gnt (gnt),
    .idx (gidx)
  );

  assign out_valid = (state_q == FULL);
  assign load      = ~out_valid | out_ready;
  // Gating with reset keeps a handshake from completing while the
  // register is being cleared.
  assign in_ready  = gnt & {N{load & ~reset}};
  assign take      = |in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (take) state_d = FULL;
      FULL:    if (out_ready && !take) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
      out_sel  <= '0;
    end else if (take) begin
      out_data <= words[gidx];
      out_sel  <= gidx;
    end
  end

`ifdef MUX_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ptr_q <= '0;
    else if (take) ptr_q <= (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
  end
`endif

endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised N-channel, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output, replacing fixed 2:1 32-bit select muxes wherever several datapath sources compete for one sink. An internal arbiter replaces the external select line and chooses the winning channel. The winner is captured into a one-entry output register that holds its data under backpressure.

## Interface
- WIDTH, 32, data bits per channel (≥1)
- N, 4, number of input channels (≥2)
- SELW, $clog2(N), width of the channel index (derived; not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  N  per-channel request; bit i belongs to channel i
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  one-hot or zero; channel i's word is accepted when in_valid[i] & in_ready[i]
- out_valid  output  1  output register holds a word
- out_ready  input  1  sink accepts a word when out_valid & out_ready
- out_data  output  WIDTH  registered winning word
- out_sel  output  SELW  index of the channel that supplied out_data

## Operation
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = ~out_valid | out_ready (the register is empty or drains this cycle).
- Grant: select one channel among the in_valid bits per the arbitration policy. in_ready = grant & {N{load}}, combinational.
- Transitions:
  - EMPTY with any in_valid: capture the granted word → FULL.
  - FULL & out_ready & any in_valid: reload the register in the same cycle and stay FULL.
  - FULL & out_ready & no in_valid → EMPTY.
  - FULL & ~out_ready: hold; out_data and out_sel stay stable and all in_ready=0.
- On capture: out_data ← granted word, out_sel ← granted index.
- No in_valid: no grant, in_ready=0, arbitration state unchanged.
- in_valid may drop without a handshake; the arbiter re-evaluates every cycle.
- Data is passed through unmodified. No width conversion or sign extension.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer=0. in_ready=0 while reset is asserted.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle while out_ready is held high.
- Assertion of reset mid-transfer discards the held word immediately; no handshake completes in that cycle.
- Combinational paths:
  - out_ready → in_ready exists.
  - in_valid → in_ready exists.
  - No path from in_data to any output exists.

## Configuration
- MUX_ARB_RR_EN defined: round-robin arbitration.
  - A SELW-bit pointer marks the highest-priority channel.
  - After a grant to channel g, the pointer becomes (g+1) mod N, wrapping N-1 → 0.
  - The pointer updates only on a completed input handshake.
- MUX_ARB_RR_EN undefined: fixed priority, lowest index wins. No pointer register exists and channel 0 can starve the others.

## Structure
- Package mux_arb_pkg holds:
  - clog2-style index-width function
  - a default width constant, 32
  - a state encoding typedef (EMPTY, FULL)
- Sub-module mux_arb_grant: N-bit request in, one-hot grant and binary index out, with the pointer input used only under MUX_ARB_RR_EN. The top level keeps the output register, state and handshake.

## Test plan
- Reset: assert reset with all in_valid=1 → out_valid=0, out_data=0, out_sel=0, in_ready=0. After deassertion (no RR), channel 0 is accepted first.
- Single channel, N=4, WIDTH=32: in_valid=4'b0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 → next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_sel=2.
- Backpressure: FULL with out_ready=0 for 5 cycles while all channels request → in_ready=0 and out_data/out_sel unchanged. When out_ready rises, one new word is captured on the next edge.
- Round robin (MUX_ARB_RR_EN): all four channels valid, out_ready=1 → out_sel sequence 0,1,2,3,0. With only channels 1 and 3 valid → 1,3,1,3.
- Fixed priority (macro off): channels 0 and 3 valid continuously → out_sel stays 0. Dropping channel 0 gives out_sel=3 on the next capture.
- Streaming: out_ready=1 with 100 random words across random channels → every accepted word appears exactly once, in acceptance order, with the correct out_sel.
